// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel framer: FSM state
// encodings and the bit-counter width helper.
package sipo_pkg;

  // 2'd3 is unused; the FSM maps it back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // Counter must represent 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_framer.sv
// Serial-to-parallel framer: collects WIDTH start-qualified serial bits
// (plus an optional even-parity bit) and presents them as one word with a
// single-cycle load strobe for the downstream parallel register.
module sipo_framer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             parity_err,
  output logic             busy,
  output logic             abort
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shift;
  logic             r_par;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_parity_err;
  logic             r_abort;

  logic             w_busy;
  logic             w_sample;
  logic             w_last_data;
  logic             w_complete;
  logic             w_abort_set;
  logic [WIDTH-1:0] w_shift_nxt;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; start always wins over a data strobe.
  always_comb begin
    // NOTE: default first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (start)            w_next_state = ST_SHIFT;
        else if (w_last_data) w_next_state = (PARITY_EN != 0) ? ST_PARITY : ST_IDLE;
      end
      ST_PARITY: begin
        if (start)          w_next_state = ST_SHIFT;
        else if (sin_valid) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output/control decode from the current state and inputs.
  always_comb begin
    w_busy      = (r_state != ST_IDLE);
    w_abort_set = start && ((r_state == ST_SHIFT) || (r_state == ST_PARITY));
    w_sample    = sin_valid && !start && (r_state == ST_SHIFT);
    w_last_data = w_sample && (r_count == CW'(WIDTH - 1));
    if (PARITY_EN != 0) w_complete = sin_valid && !start && (r_state == ST_PARITY);
    else                w_complete = w_last_data;
    if (MSB_FIRST != 0) w_shift_nxt = {r_shift[WIDTH-2:0], sin};
    else                w_shift_nxt = {sin, r_shift[WIDTH-1:1]};
  end

  // Datapath: shift register, bit counter, running parity and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_dout_valid <= w_complete;
      r_parity_err <= (PARITY_EN != 0) && w_complete && (r_par ^ sin);
      r_abort      <= w_abort_set;

      if (start) begin
        r_count <= '0;
        r_shift <= '0;
        r_par   <= 1'b0;
      end else if (w_sample) begin
        r_shift <= w_shift_nxt;
        r_count <= r_count + CW'(1);
        r_par   <= r_par ^ sin;
      end

      // With parity the word is already assembled; without it the final
      // data bit is folded in on this same edge.
      if (w_complete) r_dout <= (PARITY_EN != 0) ? r_shift : w_shift_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign parity_err = r_parity_err;
  assign abort      = r_abort;
  assign busy       = w_busy;

endmodule

// File: tb/tb_sipo_framer.sv
// Directed bench for sipo_framer: one MSB-first/parity instance and one
// LSB-first/no-parity instance, each with its own expected-word scoreboard.
module tb_sipo_framer;

  typedef struct {
    logic [3:0] d;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sin_a = 1'b0, sv_a = 1'b0, st_a = 1'b0;
  logic       sin_b = 1'b0, sv_b = 1'b0, st_b = 1'b0;
  logic [3:0] dout_a, dout_b;
  logic       dv_a, dv_b, perr_a, perr_b, busy_a, busy_b, abort_a, abort_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_valid_a = 0, n_valid_b = 0, n_abort_a = 0;

  always #5 clk = ~clk;

  sipo_framer #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(1)) dut_a (
    .clk(clk), .rst(rst), .sin(sin_a), .sin_valid(sv_a), .start(st_a),
    .dout(dout_a), .dout_valid(dv_a), .parity_err(perr_a), .busy(busy_a),
    .abort(abort_a)
  );

  sipo_framer #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(0)) dut_b (
    .clk(clk), .rst(rst), .sin(sin_b), .sin_valid(sv_b), .start(st_b),
    .dout(dout_b), .dout_valid(dv_b), .parity_err(perr_b), .busy(busy_b),
    .abort(abort_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare any produced word against the scoreboard head.
  task automatic monitor();
    exp_t e;
    if (abort_a === 1'b1) n_abort_a++;
    if (dv_a === 1'b1) begin
      n_valid_a++;
      if (q_a.size() == 0) chk("unexpected_valid_a", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("dout_a", 32'(dout_a), 32'(e.d));
        chk("perr_a", 32'(perr_a), 32'(e.perr));
      end
    end
    if (dv_b === 1'b1) begin
      n_valid_b++;
      if (q_b.size() == 0) chk("unexpected_valid_b", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("dout_b", 32'(dout_b), 32'(e.d));
        chk("perr_b", 32'(perr_b), 32'(e.perr));
      end
    end
  endtask

  // Advance one clock; observe outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic idle_a();
    sin_a = 1'($urandom); sv_a = 1'b0; st_a = 1'b0;
  endtask

  task automatic bit_a(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      sin_a = 1'($urandom); sv_a = 1'b0; st_a = 1'b0;
      tick();
    end
    sin_a = b; sv_a = 1'b1; st_a = 1'b0;
  endtask

  task automatic start_a();
    sin_a = 1'($urandom); sv_a = 1'($urandom); st_a = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
      idle_a(); tick();
    end
    chk({tag, "_drain"}, 32'(q_a.size() + q_b.size()), 0);
  endtask

  initial begin
    logic [3:0] bits;
    exp_t e;
    int   v0, a0;

    // 1: reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sin_a = 1'($urandom); sv_a = 1'($urandom); st_a = 1'($urandom);
      sin_b = 1'($urandom); sv_b = 1'($urandom); st_b = 1'($urandom);
      tick();
    end
    chk("rst_dout", 32'(dout_a), 0);
    chk("rst_valid", 32'(dv_a), 0);
    chk("rst_perr", 32'(perr_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_abort", 32'(abort_a), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    rst = 1'b0;
    sv_b = 1'b0; st_b = 1'b0;
    idle_a(); tick();

    // 2: 1011, good parity, continuous strobe
    v0 = n_valid_a; a0 = n_abort_a;
    bits = 4'b1011;
    start_a();
    chk("t2_busy", 32'(busy_a), 1);
    for (int i = 3; i >= 0; i--) begin bit_a(bits[i], 0); tick(); end
    e.d = bits; e.perr = ^bits ^ 1'b1; q_a.push_back(e);
    bit_a(1'b1, 0); tick();
    chk("t2_valid_T6", 32'(dv_a), 1);
    chk("t2_busy_T6", 32'(busy_a), 0);
    idle_a(); tick();
    chk("t2_valid_T7", 32'(dv_a), 0);
    chk("t2_hold_T7", 32'(dout_a), 32'(4'b1011));

    // 3: same word, bad parity
    start_a();
    for (int i = 3; i >= 0; i--) begin bit_a(bits[i], 0); tick(); end
    e.d = bits; e.perr = ^bits ^ 1'b0; q_a.push_back(e);
    bit_a(1'b0, 0); tick();
    chk("t3_valid", 32'(dv_a), 1);
    chk("t3_perr", 32'(perr_a), 1);

    // 4: start in the dout_valid cycle; 0110 with gaps and garbage
    start_a();
    bits = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      bit_a(bits[i], int'($urandom_range(3, 1))); tick();
    end
    e.d = bits; e.perr = ^bits ^ 1'b0; q_a.push_back(e);
    bit_a(1'b0, int'($urandom_range(3, 1))); tick();
    drain("t4");
    chk("t4_valids", 32'(n_valid_a - v0), 3);

    // 5: abort after two bits, then a full frame
    v0 = n_valid_a;
    start_a();
    bit_a(1'b1, 0); tick();
    bit_a(1'b1, 0); tick();
    start_a();
    chk("t5_abort", 32'(abort_a), 1);
    for (int i = 3; i >= 0; i--) begin bit_a(bits[i], 0); tick(); end
    chk("t5_abort_clr", 32'(abort_a), 0);
    e.d = bits; e.perr = 1'b0; q_a.push_back(e);
    bit_a(1'b0, 0); tick();
    drain("t5");
    chk("t5_valids", 32'(n_valid_a - v0), 1);
    chk("t5_aborts", 32'(n_abort_a - a0), 1);

    // 6a: reset mid-frame discards it
    v0 = n_valid_a;
    start_a();
    bit_a(1'b1, 0); tick();
    bit_a(1'b0, 0); tick();
    rst = 1'b1; idle_a(); tick();
    rst = 1'b0;
    chk("t6_busy", 32'(busy_a), 0);
    chk("t6_valid", 32'(dv_a), 0);
    for (int i = 0; i < 6; i++) begin idle_a(); tick(); end
    chk("t6_no_valid", 32'(n_valid_a - v0), 0);

    // 6b: LSB-first, no parity, bits 1,0,0,0 -> 0001 at T5
    bits = 4'b0001;
    sin_b = 1'b1; sv_b = 1'b1; st_b = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      sin_b = bits[i]; sv_b = 1'b1; st_b = 1'b0;
      if (i == 3) begin e.d = bits; e.perr = 1'b0; q_b.push_back(e); end
      tick();
      if (i < 3) chk("t6b_early", 32'(dv_b), 0);
    end
    chk("t6b_valid_T5", 32'(dv_b), 1);
    sv_b = 1'b0; sin_b = 1'b1; tick();
    chk("t6b_pulse", 32'(dv_b), 0);
    drain("t6b");
    chk("t6b_valids", 32'(n_valid_b), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_framer.md
Name: sipo_framer

Overview:
Serial-to-parallel front end that assembles framed serial bits into a WIDTH-bit word for the downstream parallel-load register. It is qualified by a bit-valid strobe and a start marker, and can check even parity. dout connects to that register's data input. dout_valid drives its load enable, so each completed frame is captured exactly once. Single clock domain.

Parameters:
WIDTH, 4, data bits per frame (legal values: 2 or more)
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0]
PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
sin  input  1  serial data bit, sampled only when sin_valid=1
sin_valid  input  1  bit strobe; cycles with sin_valid=0 are ignored
start  input  1  frame marker; sin on the start cycle is not data
dout  output  WIDTH  last completed word, held until the next completion
dout_valid  output  1  one-cycle pulse: dout was updated this cycle
parity_err  output  1  pulses together with dout_valid when parity fails
busy  output  1  high while a frame is in progress (state is not IDLE)
abort  output  1  one-cycle pulse when start arrives mid-frame

Behaviour:
- Reset values (synchronous: rst=1 at an edge): state=IDLE, bit count=0, shift register=0, dout=0, dout_valid=0, parity_err=0, abort=0, busy=0. Reset overrides all other inputs. A frame interrupted by reset is discarded with no dout_valid.
- States:
  - IDLE: start=1 -> SHIFT with count=0. The bit on the start cycle is not captured, whatever sin_valid is.
  - SHIFT: each cycle with sin_valid=1 shifts sin into the register and increments count.
    - MSB_FIRST=1: reg <= {reg[WIDTH-2:0], sin}.
    - MSB_FIRST=0: reg <= {sin, reg[WIDTH-1:1]}.
    - When the WIDTH-th bit is sampled: go to PARITY if PARITY_EN=1; otherwise complete the frame and return to IDLE.
  - PARITY: the next sin_valid=1 cycle samples the parity bit, completes the frame, and returns to IDLE.
- Completion, on the edge that samples the final bit:
  - dout <= assembled word, dout_valid <= 1.
  - parity_err <= XOR(data bits, parity bit). Even parity, so a nonzero result is an error.
  - These outputs are visible the following cycle. dout is updated even when parity fails.
- Latency, with continuous sin_valid: start at T0, data bits at T1..T(WIDTH), parity bit at T(WIDTH+1), dout_valid high at T(WIDTH+2).
- dout_valid, parity_err and abort are registered single-cycle pulses; they deassert the next cycle unless re-triggered. parity_err is always 0 when PARITY_EN=0.
- busy is decoded from the state register (state != IDLE). It is 0 during the dout_valid cycle.
- Back-to-back frames: start may be asserted in the dout_valid cycle, since state is IDLE then. The new frame is accepted.
- start during SHIFT or PARITY: the partial word is discarded, count is cleared, the block stays in or re-enters SHIFT, and abort pulses 1 next cycle. No dout_valid is produced for the aborted frame.
- start takes priority over sin_valid in the same cycle.
- The bit counter is sized to hold 0..WIDTH and never wraps past WIDTH.

Decomposition:
- Shared package/header sipo_pkg:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2 (2'd3 is illegal and recovers to IDLE).
  - counter-width function $clog2(WIDTH+1).
- No sub-module: the shift register, counter and FSM stay inline, since each is too small to justify separate verification.

Test Plan (WIDTH=4, MSB_FIRST=1, PARITY_EN=1 unless stated):
1. rst=1 for 2 cycles with random sin/start -> dout=0, dout_valid=0, parity_err=0, busy=0, abort=0.
2. start at T0; bits 1,0,1,1 at T1..T4; parity 1 at T5 (continuous sin_valid) -> at T6 dout=4'b1011, dout_valid=1, parity_err=0; at T7 dout_valid=0 and dout still 1011.
3. Same frame with parity bit 0 -> dout=4'b1011, dout_valid=1, parity_err=1 in the same cycle.
4. Bits 0,1,1,0 with sin_valid=0 gaps of 1-3 cycles, garbage on sin during the gaps, parity 0 -> dout=4'b0110, parity_err=0, exactly one dout_valid.
5. start, bits 1,1, then start again, then bits 0,1,1,0 and parity 0 -> abort pulses once; a single dout_valid with dout=4'b0110.
6. rst asserted after 2 bits -> busy=0 next cycle and no dout_valid. Then MSB_FIRST=0, PARITY_EN=0 with bits 1,0,0,0 -> dout=4'b0001, and dout_valid at T5.
